// File: rtl/mmm_mod_mul_if.sv
// Request/response bundle for the bit-serial modular multiplier.
// The requester side uses the master modport and the multiplier uses the slave modport.
interface mmm_mod_mul_if #(
  parameter int WIDTH = 260
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] N;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] result;
  logic             err;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output A, B, N, in_valid, out_ready,
    input  in_ready, result, err, out_valid
  );

  modport slave (
    input  A, B, N, in_valid, out_ready,
    output in_ready, result, err, out_valid
  );
endinterface

// File: rtl/mmm_mod_mul.sv
// Bit-serial interleaved modular multiplier: result = (A * B) mod N.
// One bit of A is consumed per clock, MSB first. Requests with N==0 or
// B>=N are rejected with err=1.
// Optional macro MMM_MOD_MUL_EARLY_EXIT_EN skips the leading zero bits of A.
// Without the macro, latency is a fixed WIDTH cycles.
module mmm_mod_mul #(
  parameter int WIDTH = 260
) (
  input  logic           clk,
  input  logic           rst_n,
  mmm_mod_mul_if.slave   bus
);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_n;
  logic [WIDTH-1:0] r_p;
  logic [WIDTH-1:0] r_result;
  logic [IW-1:0]    r_i;
  logic             r_err;

  logic             w_bad;
  logic             w_skip;
  logic [IW-1:0]    w_i_init;
  logic [WIDTH+1:0] w_t;
  logic [WIDTH+1:0] w_n_ext;
  logic [WIDTH+1:0] w_2n_ext;
  logic [WIDTH+1:0] w_t_m1n;
  logic [WIDTH+1:0] w_t_m2n;
  logic [WIDTH-1:0] w_p_nxt;

`ifdef MMM_MOD_MUL_EARLY_EXIT_EN
  // Priority encoder: index of the most significant set bit (0 when v==0).
  function automatic logic [IW-1:0] msb_index(input logic [WIDTH-1:0] v);
    logic [IW-1:0] idx;
    idx = '0;
    for (int k = 0; k < WIDTH; k++) begin
      if (v[k]) idx = IW'(k);
    end
    return idx;
  endfunction

  assign w_i_init = msb_index(bus.A);
  assign w_skip   = (bus.A == '0);
`else
  assign w_i_init = IW'(WIDTH - 1);
  assign w_skip   = 1'b0;
`endif

  assign w_bad = (bus.N == '0) || (bus.B >= bus.N);

  // One interleaved step: t = 2P + A[i]*B, then reduce t (< 3N) into [0, N).
  // Both candidate subtractions are formed in parallel with the compares.
  assign w_t      = {1'b0, r_p, 1'b0} + {2'b00, (r_a[r_i] ? r_b : {WIDTH{1'b0}})};
  assign w_n_ext  = {2'b00, r_n};
  assign w_2n_ext = {1'b0, r_n, 1'b0};
  assign w_t_m1n  = w_t - w_n_ext;
  assign w_t_m2n  = w_t - w_2n_ext;
  assign w_p_nxt  = (w_t >= w_2n_ext) ? w_t_m2n[WIDTH-1:0] :
                    (w_t >= w_n_ext)  ? w_t_m1n[WIDTH-1:0] :
                                        w_t[WIDTH-1:0];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic: rejected or all-zero requests go straight to DONE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (bus.in_valid) w_state_nxt = (w_bad || w_skip) ? DONE : MUL;
      MUL:     if (r_i == '0) w_state_nxt = DONE;
      DONE:    if (bus.out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Handshake outputs are pure decodes of the state.
  always_comb begin
    bus.in_ready  = (r_state == IDLE);
    bus.out_valid = (r_state == DONE);
    bus.result    = r_result;
    bus.err       = r_err;
  end

  // Operand capture, partial-product accumulation and result/err registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_n      <= '0;
      r_p      <= '0;
      r_i      <= '0;
      r_result <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_a      <= bus.A;
            r_b      <= bus.B;
            r_n      <= bus.N;
            r_p      <= '0;
            r_i      <= w_i_init;
            r_err    <= w_bad;
            r_result <= '0;
          end
        end
        MUL: begin
          r_p <= w_p_nxt;
          r_i <= r_i - 1'b1;
          if (r_i == '0) r_result <= w_p_nxt;
        end
        DONE: begin
          if (bus.out_ready) r_err <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mmm_mod_mul.sv
// Self-checking bench for mmm_mod_mul at WIDTH=8: vector table, random
// vectors against an arithmetic reference, plus backpressure and reset sequences.
module tb_mmm_mod_mul;
  localparam int W = 8;

  logic clk;
  logic rst_n;

  mmm_mod_mul_if #(.WIDTH(W)) bus ();

  mmm_mod_mul #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] n;
    logic [W-1:0] res;
    logic         err;
  } vec_t;

  typedef struct {
    logic [W-1:0] res;
    logic         err;
    int           lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_pass;
  int   n_total;

  task automatic check(input string name, input int act, input int req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", name, act, req);
  endtask

  // Expected cycles from the accept edge to the edge that raises out_valid.
  function automatic int exp_lat(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [W-1:0] n);
    int m;
    if (n == 0 || b >= n) return 0;
`ifdef MMM_MOD_MUL_EARLY_EXIT_EN
    if (a == 0) return 0;
    m = 0;
    for (int k = 0; k < W; k++) if (a[k]) m = k;
    return m + 1;
`else
    m = int'(a);
    return W + (m - m);
`endif
  endfunction

  // Drive one request for one clock and push its expectation.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] n, input logic [W-1:0] res,
                      input logic err);
    exp_t e;
    check("in_ready_idle", int'(bus.in_ready), 1);
    bus.A = a; bus.B = b; bus.N = n; bus.in_valid = 1'b1;
    e.res = res; e.err = err; e.lat = exp_lat(a, b, n);
    sb_q.push_back(e);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.A = W'($urandom); bus.B = W'($urandom); bus.N = W'($urandom);
  endtask

  // Wait (bounded) for out_valid, pop the expectation and compare.
  task automatic collect(input string tag, input bit release_out);
    int   lat;
    bit   busy_ok;
    exp_t e;
    lat = 0;
    busy_ok = 1'b1;
    while (!bus.out_valid && lat < 40) begin
      if (bus.in_ready !== 1'b0) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    if (!bus.out_valid) begin
      n_total++;
      $display("FAIL %s timeout: out_valid never rose within %0d cycles", tag, lat);
      return;
    end
    if (sb_q.size() == 0) begin
      n_total++;
      $display("FAIL %s scoreboard: output with no request pending, got 1 required 0", tag);
      return;
    end
    e = sb_q.pop_front();
    check({tag, " result"}, int'(bus.result), int'(e.res));
    check({tag, " err"}, int'(bus.err), int'(e.err));
    check({tag, " latency"}, lat, e.lat);
    check({tag, " in_ready_busy"}, int'(busy_ok), 1);
    check({tag, " in_ready_done"}, int'(bus.in_ready), 0);
    if (release_out) begin
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      check({tag, " out_valid_drop"}, int'(bus.out_valid), 0);
      check({tag, " err_clear"}, int'(bus.err), 0);
    end
  endtask

  vec_t tbl[10];

  initial begin
    logic [W-1:0] ra, rb, rn;
    int           ref_v;

    tbl[0] = '{a: 8'd7,   b: 8'd5,   n: 8'd13,  res: 8'd9,   err: 1'b0};
    tbl[1] = '{a: 8'd35,  b: 8'd61,  n: 8'd97,  res: 8'd1,   err: 1'b0};
    tbl[2] = '{a: 8'd255, b: 8'd250, n: 8'd251, res: 8'd247, err: 1'b0};
    tbl[3] = '{a: 8'd3,   b: 8'd13,  n: 8'd13,  res: 8'd0,   err: 1'b1};
    tbl[4] = '{a: 8'd9,   b: 8'd4,   n: 8'd0,   res: 8'd0,   err: 1'b1};
    tbl[5] = '{a: 8'd200, b: 8'd0,   n: 8'd1,   res: 8'd0,   err: 1'b0};
    tbl[6] = '{a: 8'd1,   b: 8'd5,   n: 8'd13,  res: 8'd5,   err: 1'b0};
    tbl[7] = '{a: 8'd0,   b: 8'd5,   n: 8'd13,  res: 8'd0,   err: 1'b0};
    tbl[8] = '{a: 8'd128, b: 8'd5,   n: 8'd13,  res: 8'd3,   err: 1'b0};
    tbl[9] = '{a: 8'd255, b: 8'd254, n: 8'd255, res: 8'd0,   err: 1'b0};

    n_pass = 0;
    n_total = 0;
    rst_n = 1'b0;
    bus.A = '0; bus.B = '0; bus.N = '0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("reset out_valid", int'(bus.out_valid), 0);
    check("reset result", int'(bus.result), 0);
    check("reset err", int'(bus.err), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset in_ready", int'(bus.in_ready), 1);

    // Table-driven vectors.
    for (int v = 0; v < 10; v++) begin
      send(tbl[v].a, tbl[v].b, tbl[v].n, tbl[v].res, tbl[v].err);
      collect($sformatf("vec%0d", v), 1'b1);
    end

    // Random legal vectors against an arithmetic reference.
    for (int r = 0; r < 12; r++) begin
      ra = W'($urandom);
      rn = W'($urandom_range(1, 255));
      rb = W'($urandom_range(0, int'(rn) - 1));
      ref_v = (int'(ra) * int'(rb)) % int'(rn);
      send(ra, rb, rn, W'(ref_v), 1'b0);
      collect($sformatf("rnd%0d", r), 1'b1);
    end

    // Backpressure: out_ready low for 5 cycles with in_valid pulses.
    send(8'd7, 8'd5, 8'd13, 8'd9, 1'b0);
    collect("bp", 1'b0);
    for (int c = 0; c < 5; c++) begin
      bus.A = 8'd2; bus.B = 8'd1; bus.N = 8'd3; bus.in_valid = c[0];
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      check($sformatf("bp hold out_valid c%0d", c), int'(bus.out_valid), 1);
      check($sformatf("bp hold result c%0d", c), int'(bus.result), 9);
      check($sformatf("bp hold in_ready c%0d", c), int'(bus.in_ready), 0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("bp release out_valid", int'(bus.out_valid), 0);
    check("bp release in_ready", int'(bus.in_ready), 1);
    send(8'd2, 8'd3, 8'd7, 8'd6, 1'b0);
    collect("bp_next", 1'b1);

    // Reset at cycle 4 of MUL aborts the in-flight request.
    send(8'd7, 8'd5, 8'd13, 8'd9, 1'b0);
    void'(sb_q.pop_back());
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst out_valid", int'(bus.out_valid), 0);
    check("midrst result", int'(bus.result), 0);
    check("midrst err", int'(bus.err), 0);
    check("midrst in_ready", int'(bus.in_ready), 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("midrst release in_ready", int'(bus.in_ready), 1);
    check("midrst release out_valid", int'(bus.out_valid), 0);
    send(8'd7, 8'd5, 8'd13, 8'd9, 1'b0);
    collect("after_rst", 1'b1);

    check("scoreboard empty", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
